// File: rtl/bubble_output_sequencer.sv
// ---------------------------------------------------------------------------
// bubble_output_sequencer
//
// Plays back one bubble-memory read through the output buffer. A START
// request waits for the page loader to report the buffer ready. The block
// then presents the access type and the current bit index, and issues a
// one-cycle active-low read tick once every BIT_PERIOD MCLK cycles until
// every bit of the boot loop or user page has been read. A final flush tick
// with ACCTYPE=000 returns the buffer data outputs to their idle level.
//
// Parameters
//   BIT_PERIOD   MCLK cycles per bubble bit (2..4095)
//   BOOT_LEN     bits per boot read
//   USER_LEN     bits per user-page read
//
// Ports
//   MCLK          in   48 MHz clock, rising edge
//   nRESET        in   asynchronous active-low reset
//   START         in   one-cycle request pulse, honoured only when idle
//   REQUSER       in   read type sampled with START (0 boot, 1 user)
//   BUFRDY        in   page loader reports buffer contents valid
//   ABORT         in   terminate the current read through a flush
//   ACCTYPE       out  3'b110 boot / 3'b111 user while reading, else 3'b000
//   BOUTCYCLENUM  out  current bit index
//   nBOUTCLKEN    out  read tick, low for one cycle per bit
//   BUSY          out  high from accepted START until DONE
//   DONE          out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module bubble_output_sequencer #(
    parameter int unsigned BIT_PERIOD = 480,
    parameter int unsigned BOOT_LEN   = 4106,
    parameter int unsigned USER_LEN   = 584
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic        REQUSER,
    input  logic        BUFRDY,
    input  logic        ABORT,
    output logic [2:0]  ACCTYPE,
    output logic [12:0] BOUTCYCLENUM,
    output logic        nBOUTCLKEN,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITBUF,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [11:0] PRESC_LAST = 12'(BIT_PERIOD - 1);
    localparam logic [12:0] BOOT_LAST  = 13'(BOOT_LEN - 1);
    localparam logic [12:0] USER_LAST  = 13'(USER_LEN - 1);
    localparam logic [2:0]  ACC_IDLE   = 3'b000;
    localparam logic [2:0]  ACC_BOOT   = 3'b110;
    localparam logic [2:0]  ACC_USER   = 3'b111;

    state_t      state_q, state_d;
    logic        user_q, user_d;
    logic [11:0] presc_q, presc_d;
    logic [12:0] idx_q, idx_d;
    logic [2:0]  acc_q, acc_d;
    logic        nclken_q, nclken_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        presc_wrap;
    logic [12:0] last_idx;

    // Next-state logic. Every output is a register, so each output value is
    // derived from the state that is current when the edge arrives. In
    // particular ACCTYPE keeps the read type through the cycle of the last
    // RUN tick, and only drops to 000 once the flush has begun.
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        last_idx   = user_q ? USER_LAST : BOOT_LAST;

        state_d  = state_q;
        user_d   = user_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        acc_d    = ACC_IDLE;
        nclken_d = 1'b1;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
                if (START) begin
                    user_d  = REQUSER;
                    busy_d  = 1'b1;
                    state_d = S_WAITBUF;
                end
            end

            S_WAITBUF: begin
                if (ABORT) begin
                    presc_d = '0;
                    state_d = S_FLUSH;
                end else if (BUFRDY) begin
                    presc_d = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                acc_d = user_q ? ACC_USER : ACC_BOOT;
                if (ABORT) begin
                    // An abort takes priority over a tick due on the same edge.
                    presc_d = '0;
                    state_d = S_FLUSH;
                end else begin
                    presc_d = presc_wrap ? 12'd0 : presc_q + 12'd1;
                    // The index advances on the edge that ends the tick, so
                    // it is steady for the whole tick cycle and the cycle
                    // before it.
                    if (!nclken_q) begin
                        idx_d = idx_q + 13'd1;
                    end
                    if (presc_wrap) begin
                        nclken_d = 1'b0;
                        if (idx_q == last_idx) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end

            S_FLUSH: begin
                presc_d = presc_wrap ? 12'd0 : presc_q + 12'd1;
                if (presc_wrap) begin
                    nclken_d = 1'b0;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                idx_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            user_q   <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            acc_q    <= ACC_IDLE;
            nclken_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            user_q   <= user_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            nclken_q <= nclken_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ACCTYPE      = acc_q;
    assign BOUTCYCLENUM = idx_q;
    assign nBOUTCLKEN   = nclken_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_bubble_output_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bubble_output_sequencer
//
// Self-checking bench for bubble_output_sequencer with BIT_PERIOD=4. A
// timestamp-based behavioural model predicts every output on every cycle.
// Directed scenarios pin tick counts, indices and START-to-DONE times to
// hand-computed numbers. A randomized phase then exercises START, BUFRDY,
// ABORT and reset against the model.
// ---------------------------------------------------------------------------
module tb_bubble_output_sequencer;

    localparam int P     = 4;
    localparam int BOOTL = 4106;
    localparam int USERL = 584;

    logic        MCLK    = 1'b0;
    logic        nRESET  = 1'b0;
    logic        START   = 1'b0;
    logic        REQUSER = 1'b0;
    logic        BUFRDY  = 1'b0;
    logic        ABORT   = 1'b0;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic        nBOUTCLKEN;
    logic        BUSY;
    logic        DONE;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    bubble_output_sequencer #(
        .BIT_PERIOD(P),
        .BOOT_LEN  (BOOTL),
        .USER_LEN  (USERL)
    ) dut (
        .MCLK        (MCLK),
        .nRESET      (nRESET),
        .START       (START),
        .REQUSER     (REQUSER),
        .BUFRDY      (BUFRDY),
        .ABORT       (ABORT),
        .ACCTYPE     (ACCTYPE),
        .BOUTCYCLENUM(BOUTCYCLENUM),
        .nBOUTCLKEN  (nBOUTCLKEN),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    // 100 MHz bench clock; the real part is 48 MHz, but only cycle counts matter here.
    always #5 MCLK = ~MCLK;

    // Behavioural model. A transfer is tracked by the edge on which it
    // entered RUN (tRun) or began flushing (tFlush). Ticks fall on multiples
    // of P edges after those timestamps. The index is the number of
    // completed tick periods, so it is computed directly from elapsed time.
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_FLUSH, M_END} mphase_t;
    mphase_t     mPhase  = M_IDLE;
    mphase_t     mBefore = M_IDLE;
    bit          mUser   = 1'b0;
    int          mLen    = 0;
    int          tRun    = 0;
    int          tFlush  = 0;
    int          el      = 0;
    logic [2:0]  expAcc  = 3'b000;
    logic [12:0] expIdx  = 13'd0;
    logic        expNclk = 1'b1;
    logic        expBusy = 1'b0;
    logic        expDone = 1'b0;

    always @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            mPhase  = M_IDLE;
            expAcc  = 3'b000;
            expIdx  = 13'd0;
            expNclk = 1'b1;
            expBusy = 1'b0;
            expDone = 1'b0;
        end else begin
            cyc     = cyc + 1;
            mBefore = mPhase;
            expNclk = 1'b1;
            expDone = 1'b0;
            case (mPhase)
                M_IDLE: begin
                    expIdx = 13'd0;
                    if (START) begin
                        mUser   = REQUSER;
                        mLen    = REQUSER ? USERL : BOOTL;
                        expBusy = 1'b1;
                        mPhase  = M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (ABORT) begin
                        mPhase = M_FLUSH;
                        tFlush = cyc;
                    end else if (BUFRDY) begin
                        mPhase = M_RUN;
                        tRun   = cyc;
                        expIdx = 13'd0;
                    end
                end
                M_RUN: begin
                    if (ABORT) begin
                        mPhase = M_FLUSH;
                        tFlush = cyc;
                    end else begin
                        el     = cyc - tRun;
                        expIdx = 13'((el - 1) / P);
                        if (el % P == 0) begin
                            expNclk = 1'b0;
                            if (el / P == mLen) begin
                                mPhase = M_FLUSH;
                                tFlush = cyc;
                            end
                        end
                    end
                end
                M_FLUSH: begin
                    if (cyc - tFlush == P) begin
                        expNclk = 1'b0;
                        mPhase  = M_END;
                    end
                end
                M_END: begin
                    expDone = 1'b1;
                    expBusy = 1'b0;
                    expIdx  = 13'd0;
                    mPhase  = M_IDLE;
                end
                default: mPhase = M_IDLE;
            endcase
            // ACCTYPE reflects the read type for every cycle that follows a RUN edge.
            expAcc = (mBefore == M_RUN) ? (mUser ? 3'b111 : 3'b110) : 3'b000;
        end
    end

    // Tick and completion statistics, used by the directed scenarios.
    int tickCount, userTicks, bootTicks, flushTicks;
    int firstTickCyc, firstTickIdx, lastRunIdx, prevTickCyc;
    int minGap, maxGap, lastFlushCyc, doneCyc, gap;
    int startCyc = 0;

    // Compare process: on each falling edge, check the outputs against the model and log ticks.
    always @(negedge MCLK) begin
        compared++;
        if ({ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, BUSY, DONE} !==
            {expAcc, expIdx, expNclk, expBusy, expDone}) begin
            mismatched++;
            $display("[TB] FAIL cycleCheck @%0d: got acc=%b idx=%0d nclk=%b busy=%b done=%b, expected acc=%b idx=%0d nclk=%b busy=%b done=%b",
                     cyc, ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, BUSY, DONE,
                     expAcc, expIdx, expNclk, expBusy, expDone);
        end
        if (nBOUTCLKEN === 1'b0) begin
            tickCount++;
            if (firstTickCyc < 0) begin
                firstTickCyc = cyc;
                firstTickIdx = int'(BOUTCYCLENUM);
            end
            if (prevTickCyc >= 0) begin
                gap = cyc - prevTickCyc;
                if (gap < minGap) minGap = gap;
                if (gap > maxGap) maxGap = gap;
            end
            prevTickCyc = cyc;
            if (ACCTYPE === 3'b111) userTicks++;
            else if (ACCTYPE === 3'b110) bootTicks++;
            else if (ACCTYPE === 3'b000) begin
                flushTicks++;
                lastFlushCyc = cyc;
            end
            if (ACCTYPE !== 3'b000) lastRunIdx = int'(BOUTCYCLENUM);
        end
        if (DONE === 1'b1) doneCyc = cyc;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #2;
        end
    endtask

    task automatic clearStats();
        tickCount    = 0;
        userTicks    = 0;
        bootTicks    = 0;
        flushTicks   = 0;
        firstTickCyc = -1;
        firstTickIdx = -1;
        lastRunIdx   = -1;
        prevTickCyc  = -1;
        minGap       = 1000000;
        maxGap       = 0;
        lastFlushCyc = -1;
        doneCyc      = -1;
    endtask

    task automatic applyStimulus(input bit user);
        START    = 1'b1;
        REQUSER  = user;
        startCyc = cyc;
        stepCycles(1);
        START    = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (doneCyc < 0 && n < budget) begin
            stepCycles(1);
            n++;
        end
        if (doneCyc < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitDone: got no DONE, required within %0d cycles", budget);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        int rdyCyc;
        int abortCyc;
        int n;
        clearStats();

        // Hold reset with random inputs toggling on the other pins.
        repeat (20) begin
            @(posedge MCLK);
            #2;
            START   = 1'($urandom_range(0, 1));
            REQUSER = 1'($urandom_range(0, 1));
            BUFRDY  = 1'($urandom_range(0, 1));
            ABORT   = 1'($urandom_range(0, 1));
        end
        checkOutput("reset ACCTYPE", int'(ACCTYPE), 0);
        checkOutput("reset BOUTCYCLENUM", int'(BOUTCYCLENUM), 0);
        checkOutput("reset nBOUTCLKEN", int'(nBOUTCLKEN), 1);
        checkOutput("reset BUSY", int'(BUSY), 0);
        checkOutput("reset DONE", int'(DONE), 0);

        // Release reset and keep quiet for 1000 cycles, with no START.
        START  = 1'b0;
        ABORT  = 1'b0;
        nRESET = 1'b1;
        clearStats();
        repeat (1000) begin
            BUFRDY  = 1'($urandom_range(0, 1));
            REQUSER = 1'($urandom_range(0, 1));
            ABORT   = 1'($urandom_range(0, 1));
            stepCycles(1);
        end
        ABORT = 1'b0;
        checkOutput("idle tick count", tickCount, 0);
        checkOutput("idle BUSY", int'(BUSY), 0);
        checkOutput("idle ACCTYPE", int'(ACCTYPE), 0);

        // User read with the buffer already ready.
        BUFRDY = 1'b1;
        clearStats();
        applyStimulus(1'b1);
        waitDone(5000);
        checkOutput("user START-to-DONE", doneCyc - startCyc, 2343);
        checkOutput("user ticks ACCTYPE=111", userTicks, 584);
        checkOutput("user boot-typed ticks", bootTicks, 0);
        checkOutput("user flush ticks", flushTicks, 1);
        checkOutput("user first index", firstTickIdx, 0);
        checkOutput("user last index", lastRunIdx, 583);
        checkOutput("user min tick gap", minGap, 4);
        checkOutput("user max tick gap", maxGap, 4);
        checkOutput("user flush-to-DONE", doneCyc - lastFlushCyc, 1);

        // Back-to-back user read, plus a stray START in the middle of RUN.
        clearStats();
        applyStimulus(1'b1);
        stepCycles(100);
        START   = 1'b1;
        REQUSER = 1'b0;
        stepCycles(1);
        START   = 1'b0;
        waitDone(5000);
        checkOutput("b2b START-to-DONE", doneCyc - startCyc, 2343);
        checkOutput("b2b user ticks", userTicks, 584);
        checkOutput("b2b last index", lastRunIdx, 583);

        // Boot read.
        stepCycles(3);
        clearStats();
        applyStimulus(1'b0);
        waitDone(20000);
        checkOutput("boot ticks ACCTYPE=110", bootTicks, 4106);
        checkOutput("boot last index", lastRunIdx, 4105);
        checkOutput("boot flush ticks", flushTicks, 1);
        checkOutput("boot START-to-DONE", doneCyc - startCyc, 16431);

        // Loader handshake: the buffer is not ready for 50 cycles.
        stepCycles(3);
        BUFRDY = 1'b0;
        clearStats();
        applyStimulus(1'b1);
        stepCycles(50);
        checkOutput("wait BUSY", int'(BUSY), 1);
        checkOutput("wait ACCTYPE", int'(ACCTYPE), 0);
        checkOutput("wait ticks", tickCount, 0);
        BUFRDY = 1'b1;
        rdyCyc = cyc + 1;
        waitDone(5000);
        checkOutput("handshake first tick delay", firstTickCyc - rdyCyc, 4);
        checkOutput("handshake first index", firstTickIdx, 0);

        // ABORT once the tick for index 10 has been seen; a START issued with it must be ignored.
        stepCycles(3);
        clearStats();
        applyStimulus(1'b1);
        n = 0;
        while (lastRunIdx != 10 && n < 200) begin
            stepCycles(1);
            n++;
        end
        checkOutput("abort reached index 10", lastRunIdx, 10);
        ABORT    = 1'b1;
        START    = 1'b1;
        REQUSER  = 1'b0;
        abortCyc = cyc + 1;
        stepCycles(1);
        ABORT = 1'b0;
        START = 1'b0;
        waitDone(200);
        checkOutput("abort RUN ticks", userTicks, 11);
        checkOutput("abort flush ticks", flushTicks, 1);
        checkOutput("abort flush delay", lastFlushCyc - abortCyc, 4);
        checkOutput("abort flush-to-DONE", doneCyc - lastFlushCyc, 1);
        stepCycles(5);
        checkOutput("abort post BUSY", int'(BUSY), 0);

        // Randomized phase; the model checks every cycle.
        for (int i = 0; i < 20000; i++) begin
            START   = ($urandom_range(0, 63) == 0);
            REQUSER = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) BUFRDY = ~BUFRDY;
            ABORT   = ($urandom_range(0, 2999) == 0);
            nRESET  = ($urandom_range(0, 9999) != 0);
            stepCycles(1);
        end
        nRESET = 1'b1;
        START  = 1'b0;
        ABORT  = 1'b0;
        stepCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog, in case a scenario stalls beyond its own cycle budgets.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got no end of run, required finish within 3 ms");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
